// File: rtl/mrhankey_pkg.sv
// Shared definitions for the mrhankey CPU front end: special opcodes,
// opcode classes used by the decoder, and the fetch state encoding.
package mrhankey_pkg;

  localparam logic [7:0] NOP_CODE  = 8'h88;
  localparam logic [7:0] HALT_CODE = 8'hFF;

  // Opcode class lives in IR[7:6]; NOP_CODE is ADD class with a reserved subcode.
  localparam logic [1:0] LDA = 2'b00;
  localparam logic [1:0] LDB = 2'b01;
  localparam logic [1:0] ADD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_counter.sv
// Program counter register: async clear to RESET_PC, increments by one
// when enabled and wraps modulo 2^AW.
module pc_counter #(
  parameter int              AW       = 8,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] pc
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc <= RESET_PC;
    end else if (inc) begin
      pc <= pc + AW'(1);
    end
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, reads bytes over req/ack and hands
// one registered instruction per ack to the decoder. Optional single-step
// gating is enabled by defining FETCH_STEP_EN.
module fetch
  import mrhankey_pkg::*;
#(
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          halt,
`ifdef FETCH_STEP_EN
  input  logic          step,
`endif
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [7:0]    mem_data,
  output logic [7:0]    IR,
  output logic          ir_valid,
  output logic [AW-1:0] pc,
  output logic          halted
);

  fetch_state_t state;
  logic         credit;
  logic         accept;

  // mem_req decodes registered state only, so clr drops it at once.
  assign mem_req  = (state == FETCH) && credit;
  assign mem_addr = pc;
  // A same-cycle halt wins over an ack: the byte is discarded.
  assign accept   = mem_req && mem_ack && !halt;

  pc_counter #(
    .AW       (AW),
    .RESET_PC (RESET_PC)
  ) u_pc_counter (
    .clk (clk),
    .clr (clr),
    .inc (accept),
    .pc  (pc)
  );

`ifdef FETCH_STEP_EN
  // One-deep step credit: set by a pulse, consumed by the ack it unlocks.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      credit <= 1'b0;
    end else if (state == HALTED || halt) begin
      credit <= 1'b0;
    end else if (credit) begin
      credit <= !(mem_req && mem_ack);
    end else begin
      credit <= step;
    end
  end
`else
  assign credit = 1'b1;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      IR       <= NOP_CODE;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      IR       <= NOP_CODE;
      ir_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (halt) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else begin
            state <= FETCH;
          end
        end
        FETCH: begin
          if (halt) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (accept) begin
            IR       <= mem_data;
            ir_valid <= 1'b1;
            // The halt opcode still reaches the decoder; fetching stops behind it.
            if (mem_data == HALT_CODE) begin
              state  <= HALTED;
              halted <= 1'b1;
            end
          end
        end
        HALTED: begin
          halted <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch (AW=4, RESET_PC=14): memory responder, cycle monitor with
// scoreboard of expected (IR, pc) pairs, directed and randomized programs.
module tb_fetch;
  import mrhankey_pkg::*;

  localparam int            AW  = 4;
  localparam logic [AW-1:0] RPC = 4'd14;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          halt = 1'b0;
  logic          mem_ack = 1'b0;
  logic [7:0]    mem_data = 8'h00;
  logic          mem_req, ir_valid, halted;
  logic [AW-1:0] mem_addr, pc;
  logic [7:0]    IR;
`ifdef FETCH_STEP_EN
  logic          step = 1'b1;
`endif

  always #5 clk = ~clk;

  fetch #(.AW(AW), .RESET_PC(RPC)) dut (
    .clk      (clk),
    .clr      (clr),
    .halt     (halt),
`ifdef FETCH_STEP_EN
    .step     (step),
`endif
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .IR       (IR),
    .ir_valid (ir_valid),
    .pc       (pc),
    .halted   (halted)
  );

  typedef struct {
    logic [7:0]    data;
    logic [AW-1:0] pc;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] mem [16];
  int         tests = 0;
  int         fails = 0;
  int         ack_lat = 0;
  bit         rand_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic put(input int off, input logic [7:0] v);
    mem[(int'(RPC) + off) % 16] = v;
  endtask

  // Reference: bytes are consumed in address order from RESET_PC, modulo 16,
  // up to and including the first FF; pc after each fetch is the next address.
  task automatic load_expect(output logic [AW-1:0] fin);
    int   a;
    exp_t e;
    sbq.delete();
    a = int'(RPC);
    for (int i = 0; i < 16; i++) begin
      e.data = mem[a];
      a = (a + 1) % 16;
      e.pc = AW'(a);
      sbq.push_back(e);
      if (e.data == 8'hFF) break;
    end
    fin = AW'(a);
  endtask

  // Memory responder: fixed wait-state count, or random acks including
  // spurious ones while no request is pending.
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (clr) begin
        mem_ack = 1'b0;
        wcnt = 0;
      end else if (rand_ack) begin
        mem_ack  = 1'($urandom_range(0, 1));
        mem_data = (mem_req && mem_ack) ? mem[mem_addr] : 8'($urandom);
      end else if (mem_req) begin
        if (wcnt >= ack_lat) begin
          mem_ack  = 1'b1;
          mem_data = mem[mem_addr];
          wcnt     = 0;
        end else begin
          mem_ack  = 1'b0;
          mem_data = 8'($urandom);
          wcnt++;
        end
      end else begin
        mem_ack  = 1'b0;
        mem_data = 8'($urandom);
        wcnt     = 0;
      end
    end
  end

  // Monitor: every cycle, checks against what the previous cycle implied.
  initial begin
    bit            p_acc, p_pend, e_halt;
    logic [AW-1:0] p_addr;
    exp_t          e;
    p_acc = 1'b0; p_pend = 1'b0; e_halt = 1'b0; p_addr = '0;
    forever begin
      @(negedge clk);
      #1;
      if (clr) begin
        p_acc = 1'b0; p_pend = 1'b0; e_halt = 1'b0;
      end else begin
        chk("ir_valid_timing", 32'(ir_valid), 32'(p_acc));
        if (ir_valid) begin
          if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected_fetch: got IR %0h, expected no fetch at %0t", IR, $time);
          end else begin
            e = sbq.pop_front();
            chk("ir_data", 32'(IR), 32'(e.data));
            chk("pc_after_fetch", 32'(pc), 32'(e.pc));
          end
        end else begin
          chk("ir_bubble", 32'(IR), 32'(NOP_CODE));
        end
        chk("addr_is_pc", 32'(mem_addr), 32'(pc));
        chk("halted_flag", 32'(halted), 32'(e_halt));
        if (e_halt) chk("req_low_halted", 32'(mem_req), 32'(0));
        if (p_pend) begin
          chk("req_held", 32'(mem_req), 32'(1));
          chk("addr_held", 32'(mem_addr), 32'(p_addr));
        end
        p_acc  = mem_req && mem_ack && !halt && !e_halt;
        p_pend = mem_req && !mem_ack && !halt && !e_halt;
        p_addr = mem_addr;
        if (halt || (p_acc && mem_data == 8'hFF)) e_halt = 1'b1;
      end
    end
  end

  task automatic assert_clr();
    clr = 1'b1;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'(0));
    chk("rst_pc", 32'(pc), 32'(RPC));
    chk("rst_ir", 32'(IR), 32'(NOP_CODE));
    chk("rst_ir_valid", 32'(ir_valid), 32'(0));
    chk("rst_halted", 32'(halted), 32'(0));
  endtask

  task automatic release_clr(input bit expect_fetch);
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    chk("idle_no_req", 32'(mem_req), 32'(0));
    @(negedge clk);
    if (expect_fetch) chk("fetch_req_after_idle", 32'(mem_req), 32'(1));
  endtask

  task automatic run_prog();
    logic [AW-1:0] fin;
    int n;
    if (!clr) begin
      @(negedge clk);
      #2;
      assert_clr();
    end
    @(negedge clk);
    load_expect(fin);
    release_clr(1'b1);
    n = 0;
    while (!halted && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!halted) begin
      tests++;
      fails++;
      $display("FAIL run_timeout: halted %0b after %0d cycles, expected 1", halted, n);
    end
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'(0));
    chk("final_pc", 32'(pc), 32'(fin));
    chk("final_halted", 32'(halted), 32'(1));
    chk("final_req_low", 32'(mem_req), 32'(0));
  endtask

  initial begin
    logic [AW-1:0] fin;
    int k;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    #2;
    assert_clr();

    // Basic program, ack every cycle; addresses 14,15,0,1 so pc wraps.
    ack_lat = 0;
    put(0, 8'h05); put(1, 8'h41); put(2, 8'h84); put(3, 8'hFF);
    run_prog();

    // Three wait states per access.
    ack_lat = 3;
    put(0, 8'h11); put(1, 8'h22); put(2, 8'hFF);
    run_prog();

    // Wrap 15 -> 0.
    ack_lat = 0;
    put(0, 8'h01); put(1, 8'h02); put(2, 8'h03); put(3, 8'hFF);
    run_prog();

    // External halt coincident with an ack carrying 42: byte discarded.
    put(0, 8'h42); put(1, 8'hFF);
    @(negedge clk); #2; assert_clr();
    @(negedge clk);
    sbq.delete();
    release_clr(1'b1);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    #1;
    chk("halt_ir", 32'(IR), 32'(NOP_CODE));
    chk("halt_ir_valid", 32'(ir_valid), 32'(0));
    chk("halt_pc", 32'(pc), 32'(RPC));
    chk("halt_halted", 32'(halted), 32'(1));
    chk("halt_req_low", 32'(mem_req), 32'(0));
    repeat (3) @(negedge clk);
    chk("halt_sticky", 32'(halted), 32'(1));
    chk("halt_pc_hold", 32'(pc), 32'(RPC));

    // clr in the middle of a long request, then a full restart.
    ack_lat = 6;
    put(0, 8'h31); put(1, 8'hFF);
    @(negedge clk); #2; assert_clr();
    @(negedge clk);
    load_expect(fin);
    release_clr(1'b1);
    repeat (2) @(negedge clk);
    #2;
    assert_clr();
    run_prog();
    // run_prog from HALTED exercises clr while halted.
    ack_lat = 1;
    run_prog();

    // Randomized programs and ack patterns.
    for (int r = 0; r < 12; r++) begin
      rand_ack = (r % 2) == 0;
      ack_lat  = $urandom_range(0, 2);
      k = $urandom_range(1, 15);
      for (int i = 0; i < k; i++) put(i, 8'($urandom_range(0, 254)));
      put(k, 8'hFF);
      run_prog();
    end
    rand_ack = 1'b0;

`ifdef FETCH_STEP_EN
    // Three spaced step pulses, ack latency 1: exactly three fetches.
    step = 1'b0;
    ack_lat = 1;
    for (int i = 0; i < 10; i++) put(i, 8'(8'h20 + i));
    put(10, 8'hFF);
    @(negedge clk); #2; assert_clr();
    @(negedge clk);
    load_expect(fin);
    while (sbq.size() > 3) void'(sbq.pop_back());
    release_clr(1'b0);
    for (int p = 0; p < 3; p++) begin
      @(negedge clk); step = 1'b1;
      @(negedge clk); step = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("step3_drained", 32'(sbq.size()), 32'(0));
    chk("step3_pc", 32'(pc), 32'((int'(RPC) + 3) % 16));
    chk("step3_req_low", 32'(mem_req), 32'(0));

    // Double pulse before the ack: a single fetch.
    @(negedge clk); #2; assert_clr();
    @(negedge clk);
    load_expect(fin);
    while (sbq.size() > 1) void'(sbq.pop_back());
    release_clr(1'b0);
    @(negedge clk); step = 1'b1;
    @(negedge clk);
    @(negedge clk); step = 1'b0;
    repeat (5) @(negedge clk);
    chk("step_dbl_drained", 32'(sbq.size()), 32'(0));
    chk("step_dbl_pc", 32'(pc), 32'((int'(RPC) + 1) % 16));
    chk("step_dbl_req_low", 32'(mem_req), 32'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
